// File: rtl/sa_ctrl_pkg.sv
// Shared constants, state encoding and indexing helper for the systolic array sequencer.
package sa_ctrl_pkg;

   localparam int N             = 4;
   localparam int DW            = 4;
   localparam int CW            = 8;
   localparam int DRAIN_CYC_DEF = 4;
   localparam int FEED_CYC      = 2 * N - 1;
   localparam int NE            = N * N;
   localparam int KW            = $clog2(NE);
   localparam int TW            = $clog2(FEED_CYC + 1);
   localparam int CNTW          = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_CAPTURE,
      ST_SEND,
      ST_DONE
   } state_t;

   function automatic logic [KW-1:0] elem_idx(input int r, input int c);
      return KW'(r * N + c);
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Byte-stream handshakes plus the array-facing signals of the systolic array sequencer.
interface systolic_seq_ctrl_if;
   import sa_ctrl_pkg::*;

   logic              ld_valid;
   logic [2*DW-1:0]   ld_data;
   logic              ld_ready;
   logic              start;
   logic              busy;
   logic              sa_reset;
   logic [N*DW-1:0]   sa_a;
   logic [N*DW-1:0]   sa_b;
   logic [NE*CW-1:0]  sa_c;
   logic              tx_valid;
   logic [CW-1:0]     tx_data;
   logic              tx_ready;
   logic              done;

   modport slave (
      input  ld_valid, ld_data, start, sa_c, tx_ready,
      output ld_ready, busy, sa_reset, sa_a, sa_b, tx_valid, tx_data, done
   );

   modport master (
      output ld_valid, ld_data, start, sa_c, tx_ready,
      input  ld_ready, busy, sa_reset, sa_a, sa_b, tx_valid, tx_data, done
   );

endinterface

// File: rtl/sa_skew_gen.sv
// Diagonal skew for feed step t: row i gets A[i][t-i], column j gets B[t-j][j], zero outside.
module sa_skew_gen
   import sa_ctrl_pkg::*;
(
   input  logic [TW-1:0]   t,
   input  logic [DW-1:0]   a_buf [NE],
   input  logic [DW-1:0]   b_buf [NE],
   output logic [N*DW-1:0] a_nxt,
   output logic [N*DW-1:0] b_nxt
);

   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(t) >= i && int'(t) < i + N) begin
            a_nxt[i*DW +: DW] = a_buf[elem_idx(i, int'(t) - i)];
            b_nxt[i*DW +: DW] = b_buf[elem_idx(int'(t) - i, i)];
         end
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer between the UART byte streams and the 4x4 systolic array: load operands, clear,
// skewed feed, drain, capture and byte-wise return of the sixteen results.
module systolic_seq_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int DRAIN_CYC = DRAIN_CYC_DEF
)(
   input logic                clk,
   input logic                reset,
   systolic_seq_ctrl_if.slave bus
);

   state_t            state;
   state_t            state_nxt;
   logic [CNTW-1:0]   cnt;
   logic [KW-1:0]     ld_idx;
   logic [KW-1:0]     tx_idx;
   logic [DW-1:0]     a_buf [NE];
   logic [DW-1:0]     b_buf [NE];
   logic [CW-1:0]     c_buf [NE];
   logic [N*DW-1:0]   sa_a_q;
   logic [N*DW-1:0]   sa_b_q;
   logic [N*DW-1:0]   skew_a;
   logic [N*DW-1:0]   skew_b;
   logic [TW-1:0]     feed_t;

   sa_skew_gen u_skew (
      .t     (feed_t),
      .a_buf (a_buf),
      .b_buf (b_buf),
      .a_nxt (skew_a),
      .b_nxt (skew_b)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // feed_t is the step the edge ending this cycle will present, so sa_a/sa_b are registered.
   always_comb begin
      state_nxt = state;
      feed_t    = '0;
      unique case (state)
         ST_IDLE:    if (bus.start) state_nxt = ST_CLEAR;
         ST_CLEAR:   state_nxt = ST_FEED;
         ST_FEED: begin
            feed_t = TW'(cnt + 1'b1);
            if (cnt == CNTW'(FEED_CYC - 1)) state_nxt = ST_DRAIN;
         end
         ST_DRAIN:   if (cnt == CNTW'(DRAIN_CYC - 1)) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_SEND;
         ST_SEND:    if (bus.tx_ready && tx_idx == KW'(NE - 1)) state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase

      bus.ld_ready = (state == ST_IDLE);
      bus.busy     = (state != ST_IDLE);
      bus.sa_reset = (state == ST_CLEAR);
      bus.tx_valid = (state == ST_SEND);
      bus.done     = (state == ST_DONE);
      bus.tx_data  = c_buf[tx_idx];
      bus.sa_a     = sa_a_q;
      bus.sa_b     = sa_b_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         ld_idx <= '0;
         tx_idx <= '0;
         sa_a_q <= '0;
         sa_b_q <= '0;
         for (int k = 0; k < NE; k++) begin
            a_buf[k] <= '0;
            b_buf[k] <= '0;
            c_buf[k] <= '0;
         end
      end else begin
         cnt    <= (state_nxt != state) ? '0 : cnt + 1'b1;
         sa_a_q <= (state_nxt == ST_FEED) ? skew_a : '0;
         sa_b_q <= (state_nxt == ST_FEED) ? skew_b : '0;

         // A byte arriving together with start is still stored before the index rewinds.
         if (state == ST_IDLE && bus.ld_valid) begin
            a_buf[ld_idx] <= bus.ld_data[DW-1:0];
            b_buf[ld_idx] <= bus.ld_data[2*DW-1:DW];
            ld_idx        <= ld_idx + 1'b1;
         end
         if (state == ST_IDLE && state_nxt == ST_CLEAR) ld_idx <= '0;

         if (state == ST_CAPTURE) begin
            tx_idx <= '0;
            for (int k = 0; k < NE; k++) c_buf[k] <= bus.sa_c[k*CW +: CW];
         end else if (state == ST_SEND && bus.tx_ready) begin
            tx_idx <= tx_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a behavioural 4x4 array answers on sa_c and every run's bytes
// are compared with the matrix product of the operands the bench has loaded.
module tb_systolic_seq_ctrl;
   import sa_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;

   systolic_seq_ctrl_if bus ();

   systolic_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Output-stationary array: A moves right, B moves down, each cell accumulates a*b mod 256.
   logic [7:0] acc [4][4];
   logic [3:0] pa  [4][4];
   logic [3:0] pb  [4][4];
   logic [3:0] ain [4][4];
   logic [3:0] bin [4][4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ain[i][0] = bus.sa_a[i*4 +: 4];
         bin[0][i] = bus.sa_b[i*4 +: 4];
         for (int j = 1; j < 4; j++) begin
            ain[i][j] = pa[i][j-1];
            bin[j][i] = pb[j-1][i];
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (bus.sa_reset) begin
               acc[i][j] <= '0;
               pa[i][j]  <= '0;
               pb[i][j]  <= '0;
            end else begin
               acc[i][j] <= acc[i][j] + ({4'b0, ain[i][j]} * {4'b0, bin[i][j]});
               pa[i][j]  <= ain[i][j];
               pb[i][j]  <= bin[i][j];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            bus.sa_c[(i*4+j)*8 +: 8] = acc[i][j];
   end

   // Reference copy of the operand buffers, written in load order.
   int mdl_a [16];
   int mdl_b [16];
   int mdl_k;

   logic [7:0]  rx_q [$];
   logic [15:0] log_a [$];
   logic [15:0] log_b [$];
   logic [7:0]  log_txd [$];
   bit          log_rst [$];
   bit          log_txv [$];
   bit          log_rdy [$];
   bit          log_busy [$];
   int          done_cnt;
   int          done_idx;
   bit          timed_out;

   function automatic logic [7:0] exp_c(input int n);
      int s;
      s = 0;
      for (int k = 0; k < 4; k++) s += mdl_a[(n / 4) * 4 + k] * mdl_b[k * 4 + n % 4];
      return 8'(s % 256);
   endfunction

   function automatic logic [7:0] got_byte(input int n);
      return (n < rx_q.size()) ? rx_q[n] : 8'hxx;
   endfunction

   task automatic load_byte(input int a, input int b);
      bus.ld_valid = 1'b1;
      bus.ld_data  = {4'(b), 4'(a)};
      mdl_a[mdl_k] = a;
      mdl_b[mdl_k] = b;
      mdl_k        = (mdl_k + 1) % 16;
      @(negedge clk);
      bus.ld_valid = 1'b0;
   endtask

   task automatic begin_run();
      bus.start = 1'b1;
      mdl_k     = 0;
   endtask

   // Log index i is the cycle after the (i+1)-th rising edge following the start edge.
   task automatic collect(input int start_at, input int stall_idx, input int stall_len,
                          input bit rnd_ready);
      int stall_left;
      int cyc;
      int after;
      stall_left = stall_len;
      cyc        = 0;
      after      = -1;
      rx_q.delete(); log_a.delete(); log_b.delete(); log_txd.delete();
      log_rst.delete(); log_txv.delete(); log_rdy.delete(); log_busy.delete();
      done_cnt  = 0;
      done_idx  = -1;
      timed_out = 1'b0;
      while (after != 0) begin
         @(negedge clk);
         bus.ld_valid = 1'b0;
         bus.start    = (cyc == start_at);
         if (bus.tx_valid && rx_q.size() == stall_idx && stall_left > 0) begin
            bus.tx_ready = 1'b0;
            stall_left--;
         end else begin
            bus.tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         log_a.push_back(bus.sa_a);
         log_b.push_back(bus.sa_b);
         log_txd.push_back(bus.tx_data);
         log_rst.push_back(bus.sa_reset);
         log_txv.push_back(bus.tx_valid);
         log_rdy.push_back(bus.tx_ready);
         log_busy.push_back(bus.busy);
         if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
         if (bus.done) begin
            done_cnt++;
            if (done_idx < 0) begin
               done_idx = cyc;
               after    = 6;
            end
         end
         if (after > 0) after--;
         cyc++;
         if (cyc > 400 && done_idx < 0) begin
            timed_out = 1'b1;
            after     = 0;
         end
      end
      bus.tx_ready = 1'b0;
      bus.start    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.ld_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.sa_reset !== 1'b0) begin fails++; $display("[TB] FAIL reset_sa_reset: got %b want 0", bus.sa_reset); end
      checks++; if (bus.sa_a !== 16'h0 || bus.sa_b !== 16'h0) begin fails++; $display("[TB] FAIL reset_sa_ab: got %h/%h want 0000/0000", bus.sa_a, bus.sa_b); end
      checks++; if (bus.tx_valid !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_done: got %b/%b want 0/0", bus.tx_valid, bus.done); end
      reset = 1'b1;
      for (int k = 0; k < 16; k++) begin mdl_a[k] = 0; mdl_b[k] = 0; end
      mdl_k = 0;
      @(negedge clk);
   endtask

   task automatic test_known_product();
      $display("[TB] known product with skew snapshot");
      for (int k = 0; k < 16; k++) load_byte(k / 4 + k % 4 + 1, k / 4 + 1);
      begin_run();
      collect(-1, -1, 0, 1'b0);
      checks++; if (timed_out) begin fails++; $display("[TB] FAIL known_timeout: got no done want done"); end
      for (int n = 0; n < 16; n++) begin
         checks++; if (got_byte(n) !== 8'(30 + 10 * (n / 4))) begin fails++; $display("[TB] FAIL known_byte%0d: got %0d want %0d", n, got_byte(n), 30 + 10 * (n / 4)); end
      end
      checks++; if (log_a[1] !== 16'h0001 || log_b[1] !== 16'h0001) begin fails++; $display("[TB] FAIL skew_t0: got %h/%h want 0001/0001", log_a[1], log_b[1]); end
      checks++; if (log_a[4] !== 16'h4444 || log_b[4] !== 16'h1234) begin fails++; $display("[TB] FAIL skew_t3: got %h/%h want 4444/1234", log_a[4], log_b[4]); end
      checks++; if (log_a[7] !== 16'h7000 || log_b[7] !== 16'h4000) begin fails++; $display("[TB] FAIL skew_t6: got %h/%h want 7000/4000", log_a[7], log_b[7]); end
      checks++; if (log_txv[12] !== 1'b0 || log_txv[13] !== 1'b1) begin fails++; $display("[TB] FAIL latency: got txv %b%b want 01 at cycles 13/14", log_txv[12], log_txv[13]); end
      checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL known_done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_identity();
      int rst_cycles;
      $display("[TB] identity times B");
      for (int k = 0; k < 16; k++) load_byte((k / 4 == k % 4) ? 1 : 0, k % 8);
      begin_run();
      collect(-1, -1, 0, 1'b1);
      checks++; if (timed_out) begin fails++; $display("[TB] FAIL ident_timeout: got no done want done"); end
      for (int n = 0; n < 16; n++) begin
         checks++; if (got_byte(n) !== 8'(n % 8)) begin fails++; $display("[TB] FAIL ident_byte%0d: got %0d want %0d", n, got_byte(n), n % 8); end
      end
      rst_cycles = 0;
      foreach (log_rst[i]) if (log_rst[i]) rst_cycles++;
      checks++; if (rst_cycles !== 1 || log_rst[0] !== 1'b1) begin fails++; $display("[TB] FAIL ident_sa_reset: got %0d cycles first=%b want 1 cycles first=1", rst_cycles, log_rst[0]); end
      checks++; if (log_a[1] !== 16'h0001) begin fails++; $display("[TB] FAIL ident_feed_after_clear: got %h want 0001", log_a[1]); end
   endtask

   task automatic test_backpressure();
      int stalls;
      $display("[TB] tx_ready held low at index 3");
      for (int k = 0; k < 16; k++) load_byte($urandom_range(0, 15), $urandom_range(0, 15));
      begin_run();
      collect(-1, 3, 5, 1'b0);
      checks++; if (rx_q.size() !== 16) begin fails++; $display("[TB] FAIL bp_count: got %0d bytes want 16", rx_q.size()); end
      for (int n = 0; n < 16; n++) begin
         checks++; if (got_byte(n) !== exp_c(n)) begin fails++; $display("[TB] FAIL bp_byte%0d: got %0d want %0d", n, got_byte(n), exp_c(n)); end
      end
      stalls = 0;
      foreach (log_txv[i]) begin
         if (log_txv[i] && !log_rdy[i]) begin
            stalls++;
            checks++; if (log_txd[i] !== exp_c(3)) begin fails++; $display("[TB] FAIL bp_hold: got %0d want %0d", log_txd[i], exp_c(3)); end
         end
      end
      checks++; if (stalls !== 5) begin fails++; $display("[TB] FAIL bp_stalls: got %0d want 5", stalls); end
      checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL bp_done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_abort();
      int late_done;
      $display("[TB] reset in the middle of feed");
      for (int k = 0; k < 16; k++) load_byte($urandom_range(1, 15), $urandom_range(1, 15));
      begin_run();
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b1) begin fails++; $display("[TB] FAIL abort_idle: got busy=%b ld_ready=%b want 0/1", bus.busy, bus.ld_ready); end
      checks++; if (bus.sa_a !== 16'h0 || bus.sa_b !== 16'h0) begin fails++; $display("[TB] FAIL abort_sa: got %h/%h want 0000/0000", bus.sa_a, bus.sa_b); end
      checks++; if (bus.done !== 1'b0 || bus.tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_done: got done=%b txv=%b want 0/0", bus.done, bus.tx_valid); end
      reset = 1'b1;
      for (int k = 0; k < 16; k++) begin mdl_a[k] = 0; mdl_b[k] = 0; end
      mdl_k = 0;
      late_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || bus.busy) late_done++;
      end
      checks++; if (late_done !== 0) begin fails++; $display("[TB] FAIL abort_quiet: got %0d active cycles want 0", late_done); end
      begin_run();
      collect(-1, -1, 0, 1'b1);
      checks++; if (rx_q.size() !== 16) begin fails++; $display("[TB] FAIL abort_count: got %0d bytes want 16", rx_q.size()); end
      for (int n = 0; n < 16; n++) begin
         checks++; if (got_byte(n) !== 8'h00) begin fails++; $display("[TB] FAIL abort_byte%0d: got %0d want 0", n, got_byte(n)); end
      end
   endtask

   task automatic test_start_overlap();
      int a;
      int b;
      int busy_after;
      $display("[TB] start with last byte, start during send");
      for (int k = 0; k < 15; k++) load_byte($urandom_range(0, 15), $urandom_range(0, 15));
      a = $urandom_range(1, 15);
      b = $urandom_range(1, 15);
      bus.ld_valid = 1'b1;
      bus.ld_data  = {4'(b), 4'(a)};
      mdl_a[mdl_k] = a;
      mdl_b[mdl_k] = b;
      begin_run();
      collect(15, -1, 0, 1'b0);
      checks++; if (timed_out) begin fails++; $display("[TB] FAIL overlap_timeout: got no done want done"); end
      for (int n = 0; n < 16; n++) begin
         checks++; if (got_byte(n) !== exp_c(n)) begin fails++; $display("[TB] FAIL overlap_byte%0d: got %0d want %0d", n, got_byte(n), exp_c(n)); end
      end
      busy_after = 0;
      for (int i = done_idx + 1; i < log_busy.size(); i++) if (log_busy[i]) busy_after++;
      checks++; if (busy_after !== 0 || done_cnt !== 1) begin fails++; $display("[TB] FAIL overlap_no_rerun: got busy=%0d done=%0d want 0/1", busy_after, done_cnt); end
   endtask

   task automatic test_random();
      logic [15:0] ea;
      logic [15:0] eb;
      $display("[TB] randomized runs");
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(0, 20)) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            load_byte($urandom_range(0, 15), $urandom_range(0, 15));
         end
         begin_run();
         collect(-1, -1, 0, 1'b1);
         checks++; if (timed_out || done_cnt !== 1) begin fails++; $display("[TB] FAIL rnd%0d_done: got %0d pulses timeout=%b want 1/0", r, done_cnt, timed_out); end
         for (int n = 0; n < 16; n++) begin
            checks++; if (got_byte(n) !== exp_c(n)) begin fails++; $display("[TB] FAIL rnd%0d_byte%0d: got %0d want %0d", r, n, got_byte(n), exp_c(n)); end
         end
         for (int t = 0; t < FEED_CYC + DRAIN_CYC_DEF; t++) begin
            ea = '0;
            eb = '0;
            for (int i = 0; i < 4; i++) begin
               if (t - i >= 0 && t - i < 4) begin
                  ea[i*4 +: 4] = 4'(mdl_a[i * 4 + t - i]);
                  eb[i*4 +: 4] = 4'(mdl_b[(t - i) * 4 + i]);
               end
            end
            checks++; if (log_a[t+1] !== ea || log_b[t+1] !== eb) begin fails++; $display("[TB] FAIL rnd%0d_skew_t%0d: got %h/%h want %h/%h", r, t, log_a[t+1], log_b[t+1], ea, eb); end
         end
      end
   endtask

   initial begin
      reset        = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.start    = 1'b0;
      bus.tx_ready = 1'b0;
      test_reset();
      test_known_product();
      test_identity();
      test_backpressure();
      test_abort();
      test_start_overlap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
